// File: rtl/move_strobe_gen_pkg.sv
// move_strobe_gen_pkg: direction codes shared with the mover, strobe FSM states and a one-hot filter.
package move_strobe_gen_pkg;
  localparam logic [3:0] DIR_U    = 4'd8;
  localparam logic [3:0] DIR_D    = 4'd4;
  localparam logic [3:0] DIR_R    = 4'd2;
  localparam logic [3:0] DIR_L    = 4'd1;
  localparam logic [3:0] DIR_NONE = 4'd0;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;
  // Chords are treated as released so the mover only ever sees a single direction.
  function automatic logic [3:0] to_dir(input logic [3:0] b);
    return $onehot(b) ? b : DIR_NONE;
  endfunction
endpackage

// File: rtl/move_strobe_gen_btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a stability counter that accepts a change after CYCLES mismatches.
module btn_debounce #(
  parameter int W = 4,
  parameter int CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [W-1:0] s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/move_strobe_gen.sv
// move_strobe_gen: debounced buttons to one-hot direction plus a flop-driven move strobe with auto-repeat.
module move_strobe_gen
  import move_strobe_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES = 4,
  parameter int REPEAT_DELAY = 30000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btns,
  output logic       btn_clk
);
  localparam int MAXP = (PULSE_CYCLES > REPEAT_DELAY) ?
    ((PULSE_CYCLES > REPEAT_PERIOD) ? PULSE_CYCLES : REPEAT_PERIOD) :
    ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW = $clog2(MAXP + 1);
  logic [3:0] db, dir, btns_nx;
  logic btn_clk_nx, first, first_nx;
  logic [CW-1:0] cnt, cnt_nx, wait_last;
  state_t state, state_nx;
  btn_debounce #(.W(4), .CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst(rst),
    .raw(btn_raw),
    .db(db)
  );
  assign dir = to_dir(db);
  assign wait_last = first ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      btns <= DIR_NONE;
      btn_clk <= 1'b0;
      first <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      btns <= btns_nx;
      btn_clk <= btn_clk_nx;
      first <= first_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    btns_nx = btns;
    btn_clk_nx = 1'b0;
    first_nx = first;
    cnt_nx = (cnt == CW'(MAXP)) ? cnt : cnt + 1'b1;
    case (state)
      IDLE:
        if (dir != DIR_NONE) begin
          btns_nx = dir;
          first_nx = 1'b1;
          state_nx = SETUP;
        end
      SETUP: begin
        btn_clk_nx = 1'b1;
        cnt_nx = '0;
        state_nx = PULSE;
      end
      PULSE:
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          cnt_nx = '0;
          state_nx = (dir == DIR_NONE) ? IDLE : WAIT;
          btns_nx = (dir == DIR_NONE) ? DIR_NONE : btns;
        end else btn_clk_nx = 1'b1;
      WAIT:
        if (dir == DIR_NONE) begin
          btns_nx = DIR_NONE;
          state_nx = IDLE;
        end else if (dir != btns) begin
          btns_nx = dir;
          first_nx = 1'b1;
          state_nx = SETUP;
        end else if (cnt == wait_last) begin
          first_nx = 1'b0;
          state_nx = SETUP;
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_move_strobe_gen.sv
// tb_move_strobe_gen: directed cycle-accurate checks of debounce latency, strobe timing and auto-repeat.
module tb_move_strobe_gen;
  import move_strobe_gen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] btn_raw = 4'd0;
  logic [3:0] btns;
  logic btn_clk;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  move_strobe_gen #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(2),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btns(btns),
    .btn_clk(btn_clk)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    btn_raw = 4'd0;
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    cyc = 0;
  endtask
  initial begin
    // reset held with a button pressed, then released at cycle 0
    btn_raw = 4'd8;
    step();
    repeat (3) begin
      step();
      chk("rst_btns", btns, 4'd0);
      chk("rst_clk", {3'b0, btn_clk}, 4'd0);
    end
    cyc = 0;
    rst = 1'b1;
    run_to(6); chk("rel_btns6", btns, 4'd0);
    run_to(7); chk("rel_btns7", btns, 4'd8); chk("rel_clk7", {3'b0, btn_clk}, 4'd0);
    run_to(8); chk("rel_clk8", {3'b0, btn_clk}, 4'd1);
    run_to(9); chk("rel_clk9", {3'b0, btn_clk}, 4'd1);
    run_to(10); chk("rel_clk10", {3'b0, btn_clk}, 4'd0);
    // auto-repeat, released during WAIT
    do_reset();
    btn_raw = 4'd2;
    run_to(7); chk("rep_clk7", {3'b0, btn_clk}, 4'd0);
    run_to(8); chk("rep_clk8", {3'b0, btn_clk}, 4'd1); chk("rep_btns8", btns, 4'd2);
    run_to(20); chk("rep_clk20", {3'b0, btn_clk}, 4'd0);
    run_to(21); chk("rep_clk21", {3'b0, btn_clk}, 4'd1); chk("rep_btns21", btns, 4'd2);
    run_to(24); chk("rep_btns24", btns, 4'd2);
    btn_raw = 4'd0;
    run_to(28); chk("rep_clk28", {3'b0, btn_clk}, 4'd0);
    run_to(29); chk("rep_clk29", {3'b0, btn_clk}, 4'd1); chk("rep_btns29", btns, 4'd2);
    run_to(30); chk("rep_btns30", btns, 4'd2);
    run_to(31); chk("rep_btns31", btns, 4'd0); chk("rep_clk31", {3'b0, btn_clk}, 4'd0);
    while (cyc < 40) begin
      step();
      chk("rep_quiet", {3'b0, btn_clk}, 4'd0);
    end
    // short glitch never reaches the debounced value
    do_reset();
    btn_raw = 4'd1;
    run_to(3);
    btn_raw = 4'd0;
    while (cyc < 16) begin
      step();
      chk("gl_db", dut.db, 4'd0);
      chk("gl_btns", btns, 4'd0);
      chk("gl_clk", {3'b0, btn_clk}, 4'd0);
    end
    // chord is ignored, then narrowing to one button strobes once
    do_reset();
    btn_raw = 4'b1100;
    while (cyc < 20) begin
      step();
      chk("mb_btns", btns, 4'd0);
      chk("mb_clk", {3'b0, btn_clk}, 4'd0);
    end
    cyc = 0;
    btn_raw = 4'b0100;
    run_to(6); chk("mb_btns6", btns, 4'd0);
    run_to(7); chk("mb_btns7", btns, 4'd4); chk("mb_clk7", {3'b0, btn_clk}, 4'd0);
    run_to(8); chk("mb_clk8", {3'b0, btn_clk}, 4'd1);
    run_to(10); chk("mb_clk10", {3'b0, btn_clk}, 4'd0);
    // direction change during WAIT restarts the full delay
    do_reset();
    btn_raw = 4'd8;
    run_to(8); chk("dc_clk8", {3'b0, btn_clk}, 4'd1);
    run_to(12);
    btn_raw = 4'd1;
    run_to(18); chk("dc_btns18", btns, 4'd8);
    run_to(19); chk("dc_btns19", btns, 4'd1); chk("dc_clk19", {3'b0, btn_clk}, 4'd0);
    run_to(20); chk("dc_clk20", {3'b0, btn_clk}, 4'd1);
    run_to(32); chk("dc_clk32", {3'b0, btn_clk}, 4'd0); chk("dc_btns32", btns, 4'd1);
    run_to(33); chk("dc_clk33", {3'b0, btn_clk}, 4'd1);
    // async reset in the middle of a pulse
    do_reset();
    btn_raw = 4'd8;
    run_to(9); chk("ar_clk9", {3'b0, btn_clk}, 4'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_clk", {3'b0, btn_clk}, 4'd0);
    chk("ar_btns", btns, 4'd0);
    chk("ar_state", {2'b0, dut.state}, {2'b0, IDLE});
    step();
    chk("ar_hold", {3'b0, btn_clk}, 4'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/move_strobe_gen.md
Name: move_strobe_gen

Overview:
- Upstream stage of the player-rectangle mover. Takes the raw, bouncing board push-buttons and drives that block's btns and btnClk inputs.
- Synchronizes and debounces the buttons, then reduces them to a clean one-hot direction code.
- Issues one glitch-free move strobe per step, with keyboard-style auto-repeat while a button is held.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button change is accepted (10 ms at 100 MHz).
- PULSE_CYCLES, 4, high time of btn_clk in clk cycles (≥1).
- REPEAT_DELAY, 30000000, WAIT length after the first step of a press, before auto-repeat starts.
- REPEAT_PERIOD, 10000000, WAIT length between auto-repeat steps.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- btn_raw  in  4  raw buttons {U,D,R,L} = bits [3:0]; asynchronous to clk.
- btns  out  4  registered one-hot direction: 8=U, 4=D, 2=R, 1=L, or 0 = none.
- btn_clk  out  1  registered move strobe; the downstream mover samples btns on its rising edge.

Behaviour:
- Reset (rst=0, async): btns=0, btn_clk=0, sync flops=0, db=0, all counters=0, state=IDLE.
- Synchronizer: 2-FF on all 4 bits; s = second stage.
- Debounce: register db[3:0]. A counter increments each cycle while s!=db and clears when s==db. On the DEBOUNCE_CYCLES-th consecutive mismatch cycle, db<=s and the counter clears. Latency from raw to db is 2+DEBOUNCE_CYCLES cycles.
- dir (combinational) = db when db has exactly one bit set, else 0. Multi-button presses count as released.
- FSM states: IDLE, SETUP, PULSE, WAIT. A flag "first" selects the WAIT length.
  - IDLE: btn_clk=0. If dir!=0: btns<=dir, first<=1, go to SETUP.
  - SETUP: lasts 1 cycle. btns is stable, btn_clk=0. Then btn_clk<=1, go to PULSE. This gives one full cycle of setup before the rising edge.
  - PULSE: btn_clk=1 for exactly PULSE_CYCLES cycles. btns is held and dir changes are ignored. At exit: btn_clk<=0 and go to WAIT with the counter cleared. If dir==0 at exit, go to IDLE instead and set btns<=0.
  - WAIT: lasts REPEAT_DELAY cycles if first=1, else REPEAT_PERIOD cycles.
    - If dir==0: btns<=0, go to IDLE immediately.
    - If dir!=0 and dir!=btns: btns<=dir, first<=1, go to SETUP (new press; restarts the delay).
    - On timeout: first<=0, go to SETUP with btns unchanged.
- Invariants:
  - btns never changes while btn_clk=1.
  - btns changes only in the cycle that enters SETUP or IDLE.
  - btn_clk comes straight from a flop, so it never glitches.
- Strobe spacing while a button is held:
  - First rising edge to second: PULSE_CYCLES+REPEAT_DELAY+1 cycles.
  - After that: PULSE_CYCLES+REPEAT_PERIOD+1 cycles.
- Counter widths: $clog2(max parameter + 1). Counters saturate and never wrap.
- Reset mid-operation: btn_clk drops to 0 asynchronously. No partial pulse resumes after reset is released.

Decomposition:
- Shared package:
  - direction constants DIR_U=4'd8, DIR_D=4'd4, DIR_R=4'd2, DIR_L=4'd1, DIR_NONE=4'd0, shared with the mover;
  - the FSM state enum.
- One sub-module: btn_debounce (2-FF sync plus a stability counter). Instantiated once on the 4-bit vector with parameter DEBOUNCE_CYCLES.

Test Plan (bench parameters: DEBOUNCE=4, PULSE=2, DELAY=10, PERIOD=5; cycle 0 = btn_raw change):
- Reset: hold rst=0 with btn_raw=8 → btns=0 and btn_clk=0 throughout. Release at cycle 0 with btn_raw held at 8 → btns=8 at cycle 7; btn_clk high at cycles 8–9.
- Auto-repeat: hold btn_raw=2 from cycle 0.
  - Rising edges at 8, 21, 29, 37.
  - btns=2 throughout.
  - Release at cycle 24 (in WAIT) → btns=0 at cycle 31; no edge at 37.
- Glitch rejection: btn_raw=1 for 3 cycles, then 0 → db stays 0; btns and btn_clk stay 0.
- Multi-button: btn_raw=4'b1100 held → no strobe; btns=0. Change to 4'b0100 → one strobe with btns=4, 7 cycles after the change.
- Direction change in WAIT: hold 8 until the first strobe, then switch to 1 at cycle 12 → btns=1 at cycle 19; rising edge at 20; next edge at 33, showing the full delay restarted.
- Async reset: assert rst=0 at cycle 9 (mid-PULSE) → btn_clk=0 within the same cycle, with no clk edge needed; state=IDLE.
